// File: rtl/sync5_serial_tx_pkg.sv
// Shared definitions for the 5-bit sync-code serial link: state encodings,
// default header code and a small sizing helper.
package sync5_serial_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_PAR  = 2'd3
    } state_t;

    localparam logic [4:0]  SYNC5_DEFAULT = 5'b11100;
    localparam int unsigned HDR_LEN       = 5;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync5_serial_tx_bit_tick_div.sv
// Bit-period divider: TICK marks the last of DIV cycles in each serial bit.
// The count is held at zero whenever EN is low so every bit starts aligned.
module sync5_serial_tx_bit_tick_div #(
    parameter int unsigned DIV = 4
) (
    input  logic C,
    input  logic CLR,
    input  logic EN,
    output logic TICK
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign TICK = EN && (cnt == CNT_W'(DIV - 1));

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            cnt <= '0;
        end else if (!EN || TICK) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sync5_serial_tx.sv
// Serial frame transmitter: sync header (SYNC[0] first), data LSB first, then
// one parity bit. All outputs are registered; SO idles high.
module sync5_serial_tx
    import sync5_serial_tx_pkg::*;
#(
    parameter int unsigned DIV     = 4,
    parameter int unsigned WIDTH   = 5,
    parameter logic [4:0]  SYNC    = SYNC5_DEFAULT,
    parameter bit          ODD_PAR = 1'b0
) (
    input  logic             C,
    input  logic             CLR,
    input  logic [WIDTH-1:0] D,
    input  logic             DV,
    output logic             RDY,
    output logic             SO,
    output logic             BUSY,
    output logic             FRM
);

    localparam int unsigned BIT_W = max_u(3, $clog2(WIDTH));

    state_t           state;
    logic [BIT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic             par;
    logic             tick;
    logic [2:0]       hdr_next;

    assign hdr_next = bit_cnt[2:0] + 3'd1;

    sync5_serial_tx_bit_tick_div #(
        .DIV (DIV)
    ) u_div (
        .C    (C),
        .CLR  (CLR),
        .EN   (state != ST_IDLE),
        .TICK (tick)
    );

    // Each branch sets SO to the value of the bit that starts on this edge.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            SO      <= 1'b1;
            BUSY    <= 1'b0;
            FRM     <= 1'b0;
            RDY     <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (DV) begin
                        state   <= ST_HDR;
                        shreg   <= D;
                        par     <= (^D) ^ ODD_PAR;
                        bit_cnt <= '0;
                        SO      <= SYNC[0];
                        BUSY    <= 1'b1;
                        FRM     <= 1'b1;
                        RDY     <= 1'b0;
                    end
                end
                ST_HDR: begin
                    if (tick) begin
                        FRM <= 1'b0;
                        if (bit_cnt == BIT_W'(HDR_LEN - 1)) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                            SO      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            SO      <= SYNC[hdr_next];
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_cnt == BIT_W'(WIDTH - 1)) begin
                            state   <= ST_PAR;
                            bit_cnt <= '0;
                            SO      <= par;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            SO      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
                ST_PAR: begin
                    if (tick) begin
                        state <= ST_IDLE;
                        SO    <= 1'b1;
                        BUSY  <= 1'b0;
                        RDY   <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sync5_serial_tx.sv
// Directed bench for sync5_serial_tx: a DIV=4 even-parity instance and a
// DIV=1 odd-parity instance share the stimulus; sel picks which is observed.
module tb_sync5_serial_tx;

    logic       C = 1'b0;
    logic       CLR;
    logic       DV;
    logic [4:0] D;
    logic       rdy0, so0, busy0, frm0;
    logic       rdy1, so1, busy1, frm1;
    logic       sel;
    logic       so_s, busy_s, frm_s, rdy_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 C = ~C;

    sync5_serial_tx #(
        .DIV     (4),
        .WIDTH   (5),
        .SYNC    (5'b11100),
        .ODD_PAR (1'b0)
    ) dut0 (
        .C    (C),
        .CLR  (CLR),
        .D    (D),
        .DV   (DV),
        .RDY  (rdy0),
        .SO   (so0),
        .BUSY (busy0),
        .FRM  (frm0)
    );

    sync5_serial_tx #(
        .DIV     (1),
        .WIDTH   (5),
        .SYNC    (5'b11100),
        .ODD_PAR (1'b1)
    ) dut1 (
        .C    (C),
        .CLR  (CLR),
        .D    (D),
        .DV   (DV),
        .RDY  (rdy1),
        .SO   (so1),
        .BUSY (busy1),
        .FRM  (frm1)
    );

    assign so_s   = sel ? so1   : so0;
    assign busy_s = sel ? busy1 : busy0;
    assign frm_s  = sel ? frm1  : frm0;
    assign rdy_s  = sel ? rdy1  : rdy0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".so"},   64'(so_s),   64'd1);
        check({tag, ".busy"}, 64'(busy_s), 64'd0);
        check({tag, ".rdy"},  64'(rdy_s),  64'd1);
        check({tag, ".frm"},  64'(frm_s),  64'd0);
    endtask

    // bits[i] is the i-th transmitted bit; each is expected for div cycles.
    task automatic send_frame(input string tag, input logic [4:0] data, input logic [10:0] bits,
                              input int div, input bit hold_dv, input bit inject);
        logic [43:0] trace;
        logic [43:0] exp_trace;
        int n, busy_n, frm_n, rdy_n;
        n = 11 * div;
        trace = '0;
        exp_trace = '0;
        busy_n = 0;
        frm_n = 0;
        rdy_n = 0;
        for (int i = 0; i < n; i++) exp_trace[i] = bits[i / div];
        @(negedge C);
        D  = data;
        DV = 1'b1;
        @(posedge C);
        #1;
        if (!hold_dv) DV = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                @(posedge C);
                #1;
            end
            trace[k] = so_s;
            busy_n += int'(busy_s);
            frm_n  += int'(frm_s);
            rdy_n  += int'(rdy_s);
            if (inject && k == 8) begin
                D  = 5'h0A;
                DV = 1'b1;
            end
            if (inject && k == 20) DV = 1'b0;
        end
        check({tag, ".trace"},  64'(trace),  64'(exp_trace));
        check({tag, ".busy_n"}, 64'(busy_n), 64'(n));
        check({tag, ".frm_n"},  64'(frm_n),  64'(div));
        check({tag, ".rdy_n"},  64'(rdy_n),  64'd0);
        @(posedge C);
        #1;
        check({tag, ".gap_so"},   64'(so_s),   64'd1);
        check({tag, ".gap_busy"}, 64'(busy_s), 64'd0);
        check({tag, ".gap_rdy"},  64'(rdy_s),  64'd1);
    endtask

    initial begin
        sel = 1'b0;
        DV  = 1'b0;
        D   = 5'h00;
        CLR = 1'b1;
        #2;
        check_idle("reset");
        @(negedge C);
        CLR = 1'b0;
        repeat (2) @(negedge C);

        send_frame("single", 5'b10110, 11'b11011011100, 4, 1'b0, 1'b0);

        send_frame("b2b_a", 5'h1F, 11'b11111111100, 4, 1'b1, 1'b0);
        send_frame("b2b_b", 5'h00, 11'b00000011100, 4, 1'b0, 1'b0);

        send_frame("busy_dv", 5'h06, 11'b00011011100, 4, 1'b0, 1'b1);

        // Abort during data bit 2 (samples 28..31 after accept).
        @(negedge C);
        D  = 5'b10110;
        DV = 1'b1;
        @(posedge C);
        #1;
        DV = 1'b0;
        repeat (29) @(posedge C);
        #1;
        check("abort.pre_busy", 64'(busy_s), 64'd1);
        check("abort.pre_rdy",  64'(rdy_s),  64'd0);
        #2;
        CLR = 1'b1;
        #1;
        check_idle("abort");
        @(negedge C);
        CLR = 1'b0;
        send_frame("restart", 5'h13, 11'b11001111100, 4, 1'b0, 1'b0);

        sel = 1'b1;
        send_frame("div1_odd", 5'h00, 11'b10000011100, 1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
